// File: rtl/mem_stage_rsp.sv
// rtl/mem_stage_rsp.sv - MEM stage holding loads until data_ok, buffering rdata and dropping orphaned responses
module mem_stage_rsp #(
    parameter int DATA_W          = 32,
    parameter int PC_W            = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              es_to_ms_valid,
    output logic              ms_allowin,
    input  logic [PC_W-1:0]   es_pc,
    input  logic              es_gr_we,
    input  logic [4:0]        es_dest,
    input  logic [DATA_W-1:0] es_result,
    input  logic              es_mem_req,
    input  logic [6:0]        es_load_op,
    input  logic              es_ex,
    input  logic              es_ertn,
    input  logic              es_req_inflight,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata,
    input  logic              flush,
    input  logic              ws_allowin,
    output logic              ms_to_ws_valid,
    output logic [PC_W-1:0]   ms_pc,
    output logic              ms_gr_we,
    output logic [4:0]        ms_dest,
    output logic [DATA_W-1:0] ms_result,
    output logic              ms_ex,
    output logic              ms_ertn,
    output logic [4:0]        fwd_dest,
    output logic              fwd_ready
);

    localparam int OFF_W  = $clog2(DATA_W / 8);
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int CNT_W1 = CNT_W + 1;

    logic              ms_valid;
    logic              ms_mem_req;
    logic [6:0]        ms_load_op;
    logic              ms_ex_r;
    logic              ms_ertn_r;
    logic [DATA_W-1:0] ms_result_r;
    logic              got_rsp;
    logic              buf_valid;
    logic [DATA_W-1:0] rdata_buf;
    logic [CNT_W-1:0]  cancel_cnt;

    logic              waiting;
    logic              rsp_owned;
    logic              rsp_discard;
    logic              rsp_take;
    logic              ready_go;
    logic [CNT_W1-1:0] cnt_sum;
    logic [DATA_W-1:0] rdata_sel;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_val;

    // A response belongs to MEM only once every orphaned response has drained.
    assign waiting     = ms_valid & ms_mem_req & ~got_rsp & ~buf_valid & ~ms_ex_r;
    assign rsp_owned   = data_ok & (cancel_cnt == '0);
    assign rsp_discard = data_ok & (cancel_cnt != '0);
    assign rsp_take    = rsp_owned & waiting;
    assign ready_go    = ~waiting | rsp_owned;

    assign ms_allowin     = ~ms_valid | (ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ready_go;
    assign ms_ex          = ms_valid & ms_ex_r;
    assign ms_ertn        = ms_valid & ms_ertn_r;
    assign fwd_dest       = (ms_valid & ms_gr_we) ? ms_dest : 5'd0;
    assign fwd_ready      = ~waiting;

    // Requests killed by a flush still return data; count them so they are skipped.
    always_comb begin
        cnt_sum = {1'b0, cancel_cnt};
        if (flush) begin
            cnt_sum = cnt_sum + CNT_W1'(waiting & ~rsp_owned) + CNT_W1'(es_req_inflight);
        end
        if (rsp_discard) begin
            cnt_sum = cnt_sum - CNT_W1'(1);
        end
    end

    always_comb begin
        rdata_sel = buf_valid ? rdata_buf : rdata;
        shifted   = rdata_sel >> {ms_result_r[OFF_W-1:0], 3'b000};
        load_val  = shifted;
        if (ms_load_op[0]) load_val = DATA_W'($signed(shifted[7:0]));
        if (ms_load_op[1]) load_val = DATA_W'(shifted[7:0]);
        if (ms_load_op[2]) load_val = DATA_W'($signed(shifted[15:0]));
        if (ms_load_op[3]) load_val = DATA_W'(shifted[15:0]);
        if (ms_load_op[4]) load_val = DATA_W'($signed(shifted[31:0]));
        if (ms_load_op[5]) load_val = DATA_W'(shifted[31:0]);
        ms_result = (|ms_load_op) ? load_val : ms_result_r;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid    <= 1'b0;
            got_rsp     <= 1'b0;
            buf_valid   <= 1'b0;
            rdata_buf   <= '0;
            cancel_cnt  <= '0;
            ms_pc       <= '0;
            ms_gr_we    <= 1'b0;
            ms_dest     <= 5'd0;
            ms_result_r <= '0;
            ms_mem_req  <= 1'b0;
            ms_load_op  <= 7'd0;
            ms_ex_r     <= 1'b0;
            ms_ertn_r   <= 1'b0;
        end else begin
            cancel_cnt <= cnt_sum[CNT_W-1:0];
            if (flush) begin
                ms_valid  <= 1'b0;
                got_rsp   <= 1'b0;
                buf_valid <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid  <= es_to_ms_valid;
                got_rsp   <= 1'b0;
                buf_valid <= 1'b0;
                if (es_to_ms_valid) begin
                    ms_pc       <= es_pc;
                    ms_gr_we    <= es_gr_we;
                    ms_dest     <= es_dest;
                    ms_result_r <= es_result;
                    ms_mem_req  <= es_mem_req;
                    ms_load_op  <= es_load_op;
                    ms_ex_r     <= es_ex;
                    ms_ertn_r   <= es_ertn;
                end
            end else if (rsp_take) begin
                // Still held here, so WB is stalling: keep the data before the bus moves on.
                got_rsp   <= 1'b1;
                buf_valid <= 1'b1;
                rdata_buf <= rdata;
            end
        end
    end

    cancel_cnt_bound: assert property (@(posedge clk) disable iff (!resetn)
        cnt_sum <= CNT_W1'(MAX_OUTSTANDING));

endmodule
